// File: rtl/processor_help.sv
// Shared processor types for the physical register file slice: word and physical
// register index types, machine-size constants, and the read/write/alloc request
// and response structs used between rename, issue and writeback.
package processor_help;

  localparam int XLEN                        = 32;
  localparam int PHYSICAL_REGISTER_FILE_SIZE = 64;
  localparam int SUPER_SCALAR_WIDTH          = 2;
  localparam int PREG_IDX_W                  = $clog2(PHYSICAL_REGISTER_FILE_SIZE);

  typedef logic [XLEN-1:0]       Word;
  typedef logic [PREG_IDX_W-1:0] PhysRegIdx;

  typedef struct packed {
    PhysRegIdx addr;
  } RegisterFileReadRequest;

  typedef struct packed {
    Word  data;
    logic ready;
  } RegisterFileReadResponse;

  typedef struct packed {
    logic      en;
    PhysRegIdx addr;
    Word       data;
  } RegisterFileWriteRequest;

  typedef struct packed {
    logic      en;
    PhysRegIdx addr;
  } AllocRequest;

  // A register index names real, writable storage: not the hardwired-zero p0 and
  // not beyond the end of a non-power-of-two file.
  function automatic logic idx_valid(input int unsigned idx, input int unsigned n);
    return (idx != 0) && (idx < n);
  endfunction

endpackage

// File: rtl/prf_ready_table.sv
// Scoreboard ready-bit array for the physical register file.
// Ports: clk_in/rst_in; wr_en_in/wr_addr_in (writeback sets ready);
//   alloc_en_in/alloc_addr_in (rename clears ready); flush_in (sets all);
//   ready_vec_out (registered ready bits, p0 always 1).
module prf_ready_table
  import processor_help::*;
#(
  parameter int NUM_PREGS       = PHYSICAL_REGISTER_FILE_SIZE,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_ALLOC_PORTS = 2,
  localparam int IDX_W          = $clog2(NUM_PREGS)
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic [NUM_WRITE_PORTS-1:0]                 wr_en_in,
  input  logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0]      wr_addr_in,
  input  logic [NUM_ALLOC_PORTS-1:0]                 alloc_en_in,
  input  logic [NUM_ALLOC_PORTS-1:0][IDX_W-1:0]      alloc_addr_in,
  input  logic                                       flush_in,
  output logic [NUM_PREGS-1:0]                       ready_vec_out
);

  logic [NUM_PREGS-1:0] ready_q;
  logic [NUM_PREGS-1:0] ready_d;

  // Later assignments override earlier ones, so the order below is the
  // priority order from lowest to highest: write, alloc, flush.
  always_comb begin
    ready_d = ready_q;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (wr_en_in[w] && idx_valid(32'(wr_addr_in[w]), NUM_PREGS)) begin
        ready_d[wr_addr_in[w]] = 1'b1;
      end
    end
    for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
      if (alloc_en_in[a] && idx_valid(32'(alloc_addr_in[a]), NUM_PREGS)) begin
        ready_d[alloc_addr_in[a]] = 1'b0;
      end
    end
    if (flush_in) begin
      ready_d = '1;
    end
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ready_q <= '1;
    end else begin
      ready_q <= ready_d;
    end
  end

  assign ready_vec_out = ready_q;

endmodule

// File: rtl/physical_register_file_scoreboarded.sv
// Multi-port physical register file with per-register ready scoreboard.
// Ports: rd_addr_in -> rd_data_out/rd_ready_out (combinational, optional write bypass);
//   wr_en_in/wr_addr_in/wr_data_in writeback; alloc_en_in/alloc_addr_in rename;
//   flush_in sets all ready; ready_vec_out registered ready bits for wakeup.
module physical_register_file_scoreboarded
  import processor_help::*;
#(
  parameter int NUM_PREGS       = PHYSICAL_REGISTER_FILE_SIZE,
  parameter int DATA_WIDTH      = XLEN,
  parameter int NUM_READ_PORTS  = 2 * SUPER_SCALAR_WIDTH,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_ALLOC_PORTS = 2,
  parameter bit BYPASS_EN       = 1'b1,
  localparam int IDX_W          = $clog2(NUM_PREGS)
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic [NUM_READ_PORTS-1:0][IDX_W-1:0]        rd_addr_in,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]   rd_data_out,
  output logic [NUM_READ_PORTS-1:0]                   rd_ready_out,
  input  logic [NUM_WRITE_PORTS-1:0]                  wr_en_in,
  input  logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0]       wr_addr_in,
  input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wr_data_in,
  input  logic [NUM_ALLOC_PORTS-1:0]                  alloc_en_in,
  input  logic [NUM_ALLOC_PORTS-1:0][IDX_W-1:0]       alloc_addr_in,
  input  logic                                        flush_in,
  output logic [NUM_PREGS-1:0]                        ready_vec_out
);

  logic [NUM_PREGS-1:0][DATA_WIDTH-1:0] mem_q;
  logic [NUM_PREGS-1:0]                 ready_vec;

  prf_ready_table #(
    .NUM_PREGS       (NUM_PREGS),
    .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
    .NUM_ALLOC_PORTS (NUM_ALLOC_PORTS)
  ) u_ready_table (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .wr_en_in      (wr_en_in),
    .wr_addr_in    (wr_addr_in),
    .alloc_en_in   (alloc_en_in),
    .alloc_addr_in (alloc_addr_in),
    .flush_in      (flush_in),
    .ready_vec_out (ready_vec)
  );

  // Data is stored regardless of alloc/flush on the same register. Ports are
  // visited in ascending order, so the highest-index port on a shared address wins.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (wr_en_in[w] && idx_valid(32'(wr_addr_in[w]), NUM_PREGS)) begin
          mem_q[wr_addr_in[w]] <= wr_data_in[w];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    // p0, out-of-range indices and the reset window all read as 0 / ready.
    // The bypass scan runs upward so the highest matching write port wins.
    always_comb begin
      data  = '0;
      ready = 1'b1;
      if (!rst_in && idx_valid(32'(rd_addr_in[p]), NUM_PREGS)) begin
        data  = mem_q[rd_addr_in[p]];
        ready = ready_vec[rd_addr_in[p]];
        if (BYPASS_EN) begin
          for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (wr_en_in[w] && (wr_addr_in[w] == rd_addr_in[p])) begin
              data  = wr_data_in[w];
              ready = 1'b1;
            end
          end
        end
      end
    end

    assign rd_data_out[p]  = data;
    assign rd_ready_out[p] = ready;
  end

  assign ready_vec_out = ready_vec;

endmodule

// File: tb/tb_physical_register_file_scoreboarded.sv
module tb_physical_register_file_scoreboarded;

  logic                 clk;
  logic                 rst;
  logic [3:0][5:0]      rd_addr;
  logic [3:0][31:0]     rd_data, rd_data_nb;
  logic [3:0]           rd_rdy, rd_rdy_nb;
  logic [1:0]           wr_en;
  logic [1:0][5:0]      wr_addr;
  logic [1:0][31:0]     wr_data;
  logic [1:0]           alloc_en;
  logic [1:0][5:0]      alloc_addr;
  logic                 flush;
  logic [63:0]          rvec, rvec_nb;

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_dup = 0;
  int al_dup = 0;

  // Reference model: architectural contents and ready bits.
  logic [31:0] m_data [64];
  logic        m_rdy  [64];

  physical_register_file_scoreboarded #(
    .NUM_PREGS(64), .DATA_WIDTH(32), .NUM_READ_PORTS(4),
    .NUM_WRITE_PORTS(2), .NUM_ALLOC_PORTS(2), .BYPASS_EN(1'b1)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rd_addr_in(rd_addr), .rd_data_out(rd_data),
    .rd_ready_out(rd_rdy), .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .alloc_en_in(alloc_en), .alloc_addr_in(alloc_addr), .flush_in(flush),
    .ready_vec_out(rvec)
  );

  physical_register_file_scoreboarded #(
    .NUM_PREGS(64), .DATA_WIDTH(32), .NUM_READ_PORTS(4),
    .NUM_WRITE_PORTS(2), .NUM_ALLOC_PORTS(2), .BYPASS_EN(1'b0)
  ) dut_nb (
    .clk_in(clk), .rst_in(rst), .rd_addr_in(rd_addr), .rd_data_out(rd_data_nb),
    .rd_ready_out(rd_rdy_nb), .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .alloc_en_in(alloc_en), .alloc_addr_in(alloc_addr), .flush_in(flush),
    .ready_vec_out(rvec_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream-protocol flags: duplicate write / alloc targets in one cycle.
  always @(posedge clk) begin
    if (!rst && wr_en == 2'b11 && wr_addr[0] == wr_addr[1]) wr_dup++;
    if (!rst && alloc_en == 2'b11 && alloc_addr[0] == alloc_addr[1]) al_dup++;
  end

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_data[i] = 32'h0;
      m_rdy[i]  = 1'b1;
    end
  endfunction

  function automatic void exp_rd(input logic [5:0] a, input bit byp,
                                 output logic [31:0] d, output logic r);
    d = 32'h0;
    r = 1'b1;
    if (a != 0) begin
      d = m_data[a];
      r = m_rdy[a];
      if (byp) begin
        for (int w = 1; w >= 0; w--) begin
          if (wr_en[w] && wr_addr[w] == a) begin
            d = wr_data[w];
            r = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = m_rdy[i];
    return v;
  endfunction

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = '0; alloc_addr = '0; flush = 1'b0;
    rd_addr = '0;
  endtask

  // Apply the current inputs to the model, then advance one clock.
  task automatic tick();
    if (!rst) begin
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w] && wr_addr[w] != 0) begin
          m_data[wr_addr[w]] = wr_data[w];
          m_rdy[wr_addr[w]]  = 1'b1;
        end
      end
      for (int a = 0; a < 2; a++) begin
        if (alloc_en[a] && alloc_addr[a] != 0) m_rdy[alloc_addr[a]] = 1'b0;
      end
      if (flush) for (int i = 0; i < 64; i++) m_rdy[i] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #3;
    n_cmp++;
    if (rvec !== '1 || rd_data[0] !== 32'h0 || rd_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: vec=%h data=%h rdy=%b want all-ones/0/1", rvec, rd_data[0], rd_rdy[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    wr_en[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 32'hDEAD;
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd6;
    tick();
    idle();
    rd_addr[0] = 6'd5; rd_addr[1] = 6'd6;
    #1;
    n_cmp++;
    if (rd_data[0] !== 32'hDEAD || rd_rdy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_p5: data=%h rdy6=%b want 0000dead/0", rd_data[0], rd_rdy[1]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rd_data[0] !== 32'h0 || rd_rdy[0] !== 1'b1 || rd_rdy[1] !== 1'b1 || rvec !== '1 ||
        rd_data_nb[0] !== 32'h0 || rvec_nb !== '1) begin
      n_fail++;
      $display("FAIL mid_reset: data=%h rdy=%b%b vec=%h want 0/11/all-ones", rd_data[0], rd_rdy[0], rd_rdy[1], rvec);
    end
    wr_en[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 32'h77;
    #1;
    n_cmp++;
    if (rd_data[0] !== 32'h0 || rd_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bypass_gate: data=%h rdy=%b want 0/1", rd_data[0], rd_rdy[0]);
    end
    idle();
    rd_addr[0] = 6'd5;
    rst = 1'b0;
    model_reset();
    tick();
    n_cmp++;
    if (rd_data[0] !== 32'h0 || rd_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_p5: data=%h rdy=%b want 0/1", rd_data[0], rd_rdy[0]);
    end
  endtask

  task automatic test_alloc_write();
    logic [31:0] old7;
    idle();
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd7;
    tick();
    idle();
    rd_addr[0] = 6'd7;
    #1;
    n_cmp++;
    if (rd_rdy[0] !== 1'b0 || rd_rdy_nb[0] !== 1'b0 || rvec[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_p7_rdy: rdy=%b nb=%b vec=%b want 0", rd_rdy[0], rd_rdy_nb[0], rvec[7]);
    end
    tick();
    old7 = m_data[7];
    wr_en[0] = 1'b1; wr_addr[0] = 6'd7; wr_data[0] = 32'h1234;
    #1;
    n_cmp++;
    if (rd_data[0] !== 32'h1234 || rd_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_p7: data=%h rdy=%b want 00001234/1", rd_data[0], rd_rdy[0]);
    end
    n_cmp++;
    if (rd_data_nb[0] !== old7 || rd_rdy_nb[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL nobypass_p7_same: data=%h rdy=%b want %h/0", rd_data_nb[0], rd_rdy_nb[0], old7);
    end
    tick();
    idle();
    rd_addr[0] = 6'd7;
    #1;
    n_cmp++;
    if (rd_data_nb[0] !== 32'h1234 || rd_rdy_nb[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL nobypass_p7_next: data=%h rdy=%b want 00001234/1", rd_data_nb[0], rd_rdy_nb[0]);
    end
  endtask

  task automatic test_p0();
    idle();
    wr_en[1] = 1'b1; wr_addr[1] = 6'd0; wr_data[1] = 32'hFFFF;
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd0;
    #1;
    n_cmp++;
    if (rd_data[0] !== 32'h0 || rd_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_same_cycle: data=%h rdy=%b want 0/1", rd_data[0], rd_rdy[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[0] !== 32'h0 || rd_rdy[0] !== 1'b1 || rvec[0] !== 1'b1 ||
        rd_data_nb[0] !== 32'h0 || rd_rdy_nb[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_after: data=%h rdy=%b vec0=%b want 0/1/1", rd_data[0], rd_rdy[0], rvec[0]);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    alloc_en[1] = 1'b1; alloc_addr[1] = 6'd9;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd9; wr_data[0] = 32'h55;
    tick();
    idle();
    rd_addr[2] = 6'd9;
    #1;
    n_cmp++;
    if (rd_data[2] !== 32'h55 || rd_rdy[2] !== 1'b0 || rd_data_nb[2] !== 32'h55 || rd_rdy_nb[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_write_p9: data=%h rdy=%b want 00000055/0", rd_data[2], rd_rdy[2]);
    end
    alloc_en[0] = 1'b1; alloc_addr[0] = 6'd9; flush = 1'b1;
    tick();
    idle();
    rd_addr[2] = 6'd9;
    #1;
    n_cmp++;
    if (rd_rdy[2] !== 1'b1 || rvec !== '1) begin
      n_fail++;
      $display("FAIL flush_over_alloc: rdy=%b vec=%h want 1/all-ones", rd_rdy[2], rvec);
    end
  endtask

  task automatic test_multiport();
    logic [31:0] want_d [4];
    int d0;
    int a0;
    want_d[0] = 32'hA; want_d[1] = 32'hB; want_d[2] = 32'h1234; want_d[3] = 32'h55;
    idle();
    wr_en = 2'b11;
    wr_addr[0] = 6'd3; wr_data[0] = 32'hA;
    wr_addr[1] = 6'd4; wr_data[1] = 32'hB;
    rd_addr[0] = 6'd3; rd_addr[1] = 6'd4; rd_addr[2] = 6'd7; rd_addr[3] = 6'd9;
    #1;
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (rd_data[p] !== want_d[p] || rd_rdy[p] !== 1'b1) begin
        n_fail++;
        $display("FAIL multiport_rd%0d: data=%h rdy=%b want %h/1", p, rd_data[p], rd_rdy[p], want_d[p]);
      end
    end
    tick();
    d0 = wr_dup;
    a0 = al_dup;
    idle();
    wr_en = 2'b11;
    wr_addr[0] = 6'd3; wr_data[0] = 32'h1;
    wr_addr[1] = 6'd3; wr_data[1] = 32'h2;
    alloc_en = 2'b11; alloc_addr[0] = 6'd10; alloc_addr[1] = 6'd10;
    rd_addr[0] = 6'd3;
    #1;
    n_cmp++;
    if (rd_data[0] !== 32'h2) begin
      n_fail++;
      $display("FAIL dup_write_bypass: data=%h want 00000002", rd_data[0]);
    end
    tick();
    idle();
    rd_addr[0] = 6'd3;
    #1;
    n_cmp++;
    if (rd_data_nb[0] !== 32'h2 || rvec[10] !== 1'b0) begin
      n_fail++;
      $display("FAIL dup_write_store: data=%h vec10=%b want 00000002/0", rd_data_nb[0], rvec[10]);
    end
    n_cmp++;
    if (wr_dup !== d0 + 1 || al_dup !== a0 + 1) begin
      n_fail++;
      $display("FAIL dup_flags: wr=%0d al=%0d want %0d/%0d", wr_dup, al_dup, d0 + 1, a0 + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    logic        er;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      for (int w = 0; w < 2; w++) begin
        wr_en[w]   = 1'($urandom_range(0, 1));
        wr_addr[w] = 6'($urandom_range(0, 15));
        wr_data[w] = 32'($urandom);
      end
      if (wr_en == 2'b11 && wr_addr[0] == wr_addr[1]) wr_addr[1] = wr_addr[0] + 6'd1;
      for (int a = 0; a < 2; a++) begin
        alloc_en[a]   = ($urandom_range(0, 2) == 0);
        alloc_addr[a] = 6'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 1) == 1) rd_addr[p] = wr_addr[$urandom_range(0, 1)];
        else rd_addr[p] = 6'($urandom_range(0, 63));
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        exp_rd(rd_addr[p], 1'b1, ed, er);
        n_cmp++;
        if (rd_data[p] !== ed || rd_rdy[p] !== er) begin
          n_fail++;
          $display("FAIL rand_byp c%0d p%0d a%0d: %h/%b want %h/%b", cyc, p, rd_addr[p], rd_data[p], rd_rdy[p], ed, er);
        end
        exp_rd(rd_addr[p], 1'b0, ed, er);
        n_cmp++;
        if (rd_data_nb[p] !== ed || rd_rdy_nb[p] !== er) begin
          n_fail++;
          $display("FAIL rand_nb c%0d p%0d a%0d: %h/%b want %h/%b", cyc, p, rd_addr[p], rd_data_nb[p], rd_rdy_nb[p], ed, er);
        end
      end
      n_cmp++;
      if (rvec !== exp_vec() || rvec_nb !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_vec c%0d: %h want %h", cyc, rvec, exp_vec());
      end
      if ($urandom_range(0, 49) == 0) begin
        idle();
        rd_addr[0] = 6'($urandom_range(1, 63));
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rd_data[0] !== 32'h0 || rd_rdy[0] !== 1'b1 || rvec !== '1) begin
          n_fail++;
          $display("FAIL rand_reset c%0d: %h/%b vec=%h want 0/1/all-ones", cyc, rd_data[0], rd_rdy[0], rvec);
        end
        #1;
        rst = 1'b0;
        model_reset();
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alloc_write();
    test_p0();
    test_same_cycle();
    test_multiport();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
